ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
Scan-code sequencer between the PS/2 receive FIFO (ps2_key) and the display/ASCII path.
Pops bytes from the FIFO with the ready/nextdata_n handshake and parses make, break (F0) and, optionally, extended (E0) prefixes.
Publishes a stable "current key" with a held-valid flag, a press pulse and a press counter, so the 7-seg digits blank on release and show a count.

Parameters:
DATA_WIDTH, 8, scan-code byte width; only 8 is supported.
CNT_WIDTH, 8, width of press_count; wraps modulo 2^CNT_WIDTH.

Ports:
clk  in  1  system clock, all logic on posedge
rstn  in  1  synchronous reset, active-high (asserted = 1)
ps2_data  in  DATA_WIDTH  FIFO head byte; valid while ps2_ready=1
ps2_ready  in  1  FIFO non-empty
ps2_overflow  in  1  FIFO overflow indication
count_clr  in  1  synchronous clear of press_count
nextdata_n  out  1  FIFO pop, active-low, registered, low for exactly one cycle per byte
key_code  out  DATA_WIDTH  last make code accepted
key_ext  out  1  key_code was E0-prefixed
key_valid  out  1  key currently held (display enable)
key_press  out  1  one-cycle pulse on each new press
press_count  out  CNT_WIDTH  number of new presses
overflow_err  out  1  sticky overflow flag

Behaviour:
- Reset values: nextdata_n=1, key_code=0, key_ext=0, key_valid=0, key_press=0, press_count=0, overflow_err=0, state=IDLE, brk=0, ext=0.
- Reset mid-sequence aborts any pop. A pop in flight is not completed; the byte stays in the FIFO.
- FSM states: IDLE, POP, PROC.
- IDLE: if ps2_ready=1, latch ps2_data into byte_r, register nextdata_n<=0, go to POP. Otherwise stay.
- POP: nextdata_n=0 this cycle, so the FIFO advances at the end of the cycle. Register nextdata_n<=1, go to PROC.
- PROC: decode byte_r, then go to IDLE. nextdata_n=1.
- Throughput: 1 byte per 3 cycles. Latency from ps2_ready rising to key_press pulse is 3 cycles (pulse is visible in the cycle after PROC).
- Decode in PROC:
  - byte_r==8'hF0: set brk=1.
  - byte_r==8'hE0: set ext=1 (EXT_KEY_EN only).
  - Other byte with brk=0 (make):
    - If key_valid=1, byte_r==key_code and ext==key_ext: typematic repeat. No count increment, no pulse.
    - Otherwise: key_code<=byte_r, key_ext<=ext, key_valid<=1, key_press<=1 for one cycle, press_count<=press_count+1 (wraps to 0).
  - Other byte with brk=1 (break): if byte_r==key_code and ext==key_ext, key_valid<=0. Otherwise ignore (another key released).
  - After every non-prefix byte, clear brk and ext.
- key_press is 0 in every cycle except the single cycle after a new-press PROC.
- count_clr=1 sets press_count<=0. If it coincides with an increment, the clear wins and the press is not counted; key_press still pulses.
- ps2_overflow=1 in any cycle sets overflow_err=1. Only reset clears it. Decoding continues unaffected.
- Prefix F0 followed by E0 is accepted in either order; both flags apply to the next non-prefix byte.

Optional Feature:
Macro: PS2_EXT_KEY_EN.
- Defined: E0 sets ext, and key_ext reflects it. Extended keys are distinct from plain keys with the same code.
- Undefined: E0 bytes are popped and discarded, ext stays 0, and key_ext is tied to 0.

Decomposition:
- Package ps2_pkg holds:
  - constants SC_BREAK=8'hF0 and SC_EXT=8'hE0;
  - the FSM state encoding (IDLE=2'd0, POP=2'd1, PROC=2'd2);
  - the DATA_WIDTH default.
- Single module; no sub-module is warranted. The counter and FSM are small and tightly coupled.

Test Plan:
- Reset: hold rstn=1 for 2 cycles with ps2_ready=1 -> nextdata_n stays 1, all outputs 0, no FIFO byte consumed.
- Single press 8'h1C, then F0,1C -> key_code=8'h1C, key_valid=1, key_press one pulse, press_count=1. After the break, key_valid=0 and key_code stays 8'h1C. Exactly 3 pops, each nextdata_n low 1 cycle.
- Typematic: 1C,1C,1C,F0,1C -> press_count=1, single key_press pulse, key_valid drops only after the final byte.
- Foreign break: press 1C, then press 32, then F0,1C -> key_code=8'h32, key_valid stays 1, press_count=2.
- Extended (macro on): E0,75 then 75 -> press_count=2, key_ext 1 then 0. Macro off: same stream -> press_count=1, key_ext=0.
- Counter wrap and clear: 256 distinct press/release pairs -> press_count wraps to 0. count_clr asserted in the same cycle as a press -> press_count=0 and key_press pulses. A ps2_overflow pulse -> overflow_err=1 until reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM encoding and default widths for the PS/2 key sequencer.
package ps2_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 8;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PROC = 2'd2
  } state_t;

  // F0 and E0 only modify how the following byte is interpreted.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_BREAK) || (b == SC_EXT);
  endfunction

endpackage

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: pops the receive FIFO, tracks make/break/E0 (E0 honoured only with PS2_EXT_KEY_EN).
// One byte per 3 cycles, key_press 3 cycles after ps2_ready; waits on ps2_ready, pops with a 1-cycle nextdata_n low.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] ps2_data,
  input  logic                  ps2_ready,
  input  logic                  ps2_overflow,
  input  logic                  count_clr,
  output logic                  nextdata_n,
  output logic [DATA_WIDTH-1:0] key_code,
  output logic                  key_ext,
  output logic                  key_valid,
  output logic                  key_press,
  output logic [CNT_WIDTH-1:0]  press_count,
  output logic                  overflow_err
);

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] byte_r, byte_nx;
  logic                  brk, brk_nx;
  logic                  ext, ext_nx;
  logic                  nextdata_n_nx;
  logic [DATA_WIDTH-1:0] key_code_nx;
  logic                  key_ext_nx;
  logic                  key_valid_nx;
  logic                  key_press_nx;
  logic [CNT_WIDTH-1:0]  press_count_nx;
  logic                  overflow_err_nx;
  logic                  cnt_inc;
  logic                  same_key;

  assign same_key = (byte_r == key_code) && (ext == key_ext);

  always_comb begin
    state_nx        = state;
    byte_nx         = byte_r;
    brk_nx          = brk;
    ext_nx          = ext;
    nextdata_n_nx   = 1'b1;
    key_code_nx     = key_code;
    key_ext_nx      = key_ext;
    key_valid_nx    = key_valid;
    key_press_nx    = 1'b0;
    overflow_err_nx = overflow_err | ps2_overflow;
    cnt_inc         = 1'b0;

    case (state)
      IDLE: begin
        if (ps2_ready) begin
          byte_nx       = ps2_data;
          nextdata_n_nx = 1'b0;
          state_nx      = POP;
        end
      end
      POP: begin
        state_nx = PROC;
      end
      PROC: begin
        state_nx = IDLE;
        if (byte_r == DATA_WIDTH'(SC_BREAK)) begin
          brk_nx = 1'b1;
        end else if (byte_r == DATA_WIDTH'(SC_EXT)) begin
`ifdef PS2_EXT_KEY_EN
          ext_nx = 1'b1;
`endif
        end else begin
          if (!brk) begin
            // A make for the key already held is typematic repeat, not a new press.
            if (!(key_valid && same_key)) begin
              key_code_nx  = byte_r;
              key_ext_nx   = ext;
              key_valid_nx = 1'b1;
              key_press_nx = 1'b1;
              cnt_inc      = 1'b1;
            end
          end else if (same_key) begin
            key_valid_nx = 1'b0;
          end
          brk_nx = 1'b0;
          ext_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (count_clr)
      press_count_nx = '0;
    else
      press_count_nx = press_count + {{(CNT_WIDTH-1){1'b0}}, cnt_inc};
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state        <= IDLE;
      byte_r       <= '0;
      brk          <= 1'b0;
      ext          <= 1'b0;
      nextdata_n   <= 1'b1;
      key_code     <= '0;
      key_ext      <= 1'b0;
      key_valid    <= 1'b0;
      key_press    <= 1'b0;
      press_count  <= '0;
      overflow_err <= 1'b0;
    end else begin
      state        <= state_nx;
      byte_r       <= byte_nx;
      brk          <= brk_nx;
      ext          <= ext_nx;
      nextdata_n   <= nextdata_n_nx;
      key_code     <= key_code_nx;
      key_ext      <= key_ext_nx;
      key_valid    <= key_valid_nx;
      key_press    <= key_press_nx;
      press_count  <= press_count_nx;
      overflow_err <= overflow_err_nx;
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomised scoreboard bench for ps2_key_ctrl; FIFO and key-state reference model live in the bench.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       count_clr;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       key_press;
  logic [7:0] press_count;
  logic       overflow_err;

  ps2_key_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ps2_data     (ps2_data),
    .ps2_ready    (ps2_ready),
    .ps2_overflow (ps2_overflow),
    .count_clr    (count_clr),
    .nextdata_n   (nextdata_n),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_valid    (key_valid),
    .key_press    (key_press),
    .press_count  (press_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         clr;
  } item_t;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       valid;
    logic       press;
    logic [7:0] cnt;
  } exp_t;

  item_t fifo[$];
  exp_t  expq[$];

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int presses_seen = 0;
  int presses_exp = 0;
  bit clr_pending = 0;

`ifdef PS2_EXT_KEY_EN
  localparam bit EXT_ON = 1'b1;
`else
  localparam bit EXT_ON = 1'b0;
`endif

  // Reference key state: what a keyboard user would expect to see after each byte.
  bit         m_brk, m_ext, m_valid, m_kext;
  logic [7:0] m_code;
  int         m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_valid = 0; m_kext = 0; m_code = 8'h00; m_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit clr);
    exp_t  e;
    item_t it;
    bit    press = 0;
    if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      if (EXT_ON) m_ext = 1;
    end else begin
      if (!m_brk) begin
        if (!(m_valid && m_code == b && m_kext == m_ext)) begin
          m_code = b; m_kext = m_ext; m_valid = 1; press = 1;
          m_cnt = (m_cnt + 1) % 256;
          presses_exp++;
        end
      end else if (m_code == b && m_kext == m_ext) begin
        m_valid = 0;
      end
      m_brk = 0; m_ext = 0;
    end
    if (clr) m_cnt = 0;
    e.code = m_code; e.ext = m_kext; e.valid = m_valid; e.press = press; e.cnt = 8'(m_cnt);
    expq.push_back(e);
    it.b = b; it.clr = clr;
    fifo.push_back(it);
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo.size() != 0 || expq.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(fifo.size() + expq.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  // FIFO model: head presented while non-empty, popped when nextdata_n is seen low.
  always @(negedge clk) begin
    count_clr   = clr_pending;
    clr_pending = 0;
    if (!rstn && nextdata_n == 1'b0 && fifo.size() > 0) begin
      clr_pending = fifo[0].clr;
      void'(fifo.pop_front());
      pops++;
    end
    ps2_ready = (fifo.size() > 0);
    ps2_data  = (fifo.size() > 0) ? fifo[0].b : 8'h00;
  end

  // Monitor: the key state is compared two negedges after each observed pop.
  bit p1 = 0, p2 = 0, prev_low = 0;
  always @(negedge clk) begin
    if (rstn) begin
      p1 = 0; p2 = 0; prev_low = 0;
    end else begin
      if (key_press) presses_seen++;
      if (p2) begin
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte actual=output required=none");
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk($sformatf("key_state@%0t", $time),
              {13'd0, key_code, key_ext, key_valid, key_press, press_count},
              {13'd0, e.code, e.ext, e.valid, e.press, e.cnt});
        end
      end else if (key_press) begin
        errors++;
        $display("FAIL stray_key_press actual=1 required=0");
      end
      if (!nextdata_n && prev_low) begin
        errors++;
        $display("FAIL nextdata_n_width actual=2+ required=1");
      end
      prev_low = !nextdata_n;
      p2 = p1;
      p1 = !nextdata_n;
    end
  end

  initial begin
    rstn = 1'b1; ps2_overflow = 1'b0; count_clr = 1'b0;
    ps2_ready = 1'b0; ps2_data = 8'h00;
    model_reset();
    send(8'h1C, 0);
    @(negedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("rst_nextdata_n", 32'(nextdata_n), 1);
      chk("rst_outputs", {key_code, key_ext, key_valid, key_press, press_count, overflow_err}, 0);
    end
    chk("rst_no_pop", 32'(fifo.size()), 1);
    rstn = 1'b0;

    send(8'hF0, 0); send(8'h1C, 0);
    drain();
    chk("single_pops", 32'(pops), 3);
    chk("single_release", {key_code, key_valid}, {8'h1C, 1'b0});

    send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    drain();

    send(8'h1C, 0); send(8'h32, 0); send(8'hF0, 0); send(8'h1C, 0);
    drain();
    chk("foreign_break", {key_code, key_valid}, {8'h32, 1'b1});

    send(8'hE0, 0); send(8'h75, 0); send(8'h75, 0); send(8'hF0, 0); send(8'hE0, 0); send(8'h75, 0);
    drain();

    for (int i = 0; i < 300; i++) begin
      logic [7:0] pool [6];
      logic [7:0] b;
      pool = '{8'h1C, 8'h32, 8'h75, 8'hF0, 8'hE0, 8'h1C};
      b = ($urandom_range(0, 7) < 6) ? pool[$urandom_range(0, 5)] : 8'($urandom);
      send(b, $urandom_range(0, 15) == 0);
    end
    drain();

    send(8'h29, 0); send(8'h2A, 1);
    drain();
    chk("clr_wins", 32'(press_count), 0);

    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = 8'((i % 100) + 1);
      send(c, 0); send(8'hF0, 0); send(c, 0);
    end
    drain();
    chk("count_wrap", {key_valid, press_count}, 0);
    chk("press_pulses", 32'(presses_seen), 32'(presses_exp));

    chk("ovf_before", 32'(overflow_err), 0);
    ps2_overflow = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    repeat (2) @(negedge clk);
    chk("ovf_set", 32'(overflow_err), 1);
    send(8'h44, 0);
    drain();
    chk("ovf_sticky", 32'(overflow_err), 1);

    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("final_reset", {key_code, key_ext, key_valid, key_press, press_count, overflow_err, nextdata_n}, 1);
    rstn = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
